// File: rtl/iob_ctls_iter.sv
// Iterative count-leading/trailing-zeros/ones unit: scans a W-bit word C bits per clock
// behind valid/ready handshakes. Optional build macro: IOB_CTLS_ITER_EARLY_EXIT_EN.
module iob_ctls_iter #(
    parameter int W = 32,
    parameter int C = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cke_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic [W-1:0]         data_i,
    input  logic [1:0]           mode_i,
    output logic                 count_valid_o,
    input  logic                 count_ready_i,
    output logic [$clog2(W):0]   count_o,
    output logic [1:0]           state_o
);

    localparam int N  = W / C;
    localparam int CW = $clog2(W) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Handshakes: a transfer happens on an enabled rising edge where valid and ready are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   data_q;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  acc;
`ifndef IOB_CTLS_ITER_EARLY_EXIT_EN
    logic           found;
`endif

    logic [C-1:0]   chunk;
    logic [CW-1:0]  run;
    logic [CW-1:0]  acc_next;
    logic           chunk_all;
    logic           last;
    logic           finish;

    // The word is normalised at accept time so the scan always counts zeros from the LSB:
    // leading mode bit-reverses it, ones mode inverts it.
    function automatic logic [W-1:0] normalise(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] r;
        r = d;
        if (m[0]) begin
            for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        end
        if (m[1]) r = ~r;
        return r;
    endfunction

    function automatic logic [CW-1:0] trailing_zeros(input logic [C-1:0] c);
        logic [CW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < C; i++) begin
            if (c[i]) hit = 1'b1;
            else if (!hit) n = n + 1'b1;
        end
        return n;
    endfunction

    always_comb begin
        chunk     = data_q[C-1:0];
        run       = trailing_zeros(chunk);
        chunk_all = ~|chunk;
        last      = (idx == IW'(N - 1));
`ifdef IOB_CTLS_ITER_EARLY_EXIT_EN
        acc_next  = acc + run;
        finish    = !chunk_all || last;
`else
        // Once a non-symbol bit has been seen the run is over; later chunks add nothing.
        acc_next  = found ? acc : acc + run;
        finish    = last;
`endif
    end

    assign state_o = state;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state         <= IDLE;
            data_q        <= '0;
            idx           <= '0;
            acc           <= '0;
            data_ready_o  <= 1'b1;
            count_valid_o <= 1'b0;
            count_o       <= '0;
`ifndef IOB_CTLS_ITER_EARLY_EXIT_EN
            found         <= 1'b0;
`endif
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (data_valid_i && data_ready_o) begin
                        data_q       <= normalise(data_i, mode_i);
                        idx          <= '0;
                        acc          <= '0;
`ifndef IOB_CTLS_ITER_EARLY_EXIT_EN
                        found        <= 1'b0;
`endif
                        data_ready_o <= 1'b0;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    if (finish) begin
                        count_o       <= acc_next;
                        count_valid_o <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                        data_q <= data_q >> C;
`ifndef IOB_CTLS_ITER_EARLY_EXIT_EN
                        found  <= found | !chunk_all;
`endif
                    end
                end
                DONE: begin
                    if (count_ready_i) begin
                        count_valid_o <= 1'b0;
                        data_ready_o  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
